// File: rtl/rat_uart_tx.sv
// Transmit-only UART for the RAT MCU: a 4-deep byte FIFO written from the
// output-port bus feeding an 8N1 serializer, with status byte and done interrupt.
module rat_uart_tx #(
  parameter int unsigned CLKS_PER_BIT = 868,
  parameter logic [7:0]  TX_DATA_ID   = 8'h40,
  parameter logic [7:0]  TX_STAT_ID   = 8'h41
) (
  input  logic       CLK,
  input  logic       RESET_N,
  input  logic [7:0] PORT_ID,
  input  logic [7:0] OUT_PORT,
  input  logic       IO_STRB,
  output logic       TX,
  output logic [7:0] STATUS,
  output logic       INTR
);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_e;

  state_e      state_q;
  logic [11:0] baud_q;
  logic [2:0]  bit_q;
  logic [7:0]  shift_q;
  logic        tx_q;
  logic        intr_q;

  logic [7:0]  mem_q [4];
  logic [1:0]  wr_ptr_q, rd_ptr_q;
  logic [2:0]  count_q, count_d;
  logic        ovf_q;

  logic wr_data, wr_stat, full, empty, baud_done, pop, push;

  assign wr_data   = IO_STRB && (PORT_ID == TX_DATA_ID);
  assign wr_stat   = IO_STRB && (PORT_ID == TX_STAT_ID);
  assign full      = (count_q == 3'd4);
  assign empty     = (count_q == 3'd0);
  assign baud_done = (baud_q == 12'(CLKS_PER_BIT - 1));

  // A pop frees a slot on the same edge, so a write to a full FIFO that
  // coincides with a pop is still accepted.
  assign pop     = !empty && ((state_q == IDLE) || (state_q == STOP && baud_done));
  assign push    = wr_data && (!full || pop);
  assign count_d = count_q + 3'(push) - 3'(pop);

  always_ff @(posedge CLK) begin
    if (push) mem_q[wr_ptr_q] <= OUT_PORT;
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 2'd1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 2'd1;
      count_q <= count_d;
      if (wr_stat)              ovf_q <= 1'b0;
      else if (wr_data && !push) ovf_q <= 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q <= IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
      intr_q  <= 1'b0;
    end else begin
      intr_q <= 1'b0;
      case (state_q)
        IDLE: begin
          tx_q   <= 1'b1;
          baud_q <= '0;
          if (pop) begin
            shift_q <= mem_q[rd_ptr_q];
            state_q <= START;
            tx_q    <= 1'b0;
          end
        end
        START: begin
          if (baud_done) begin
            baud_q  <= '0;
            bit_q   <= '0;
            state_q <= DATA;
            tx_q    <= shift_q[0];
          end else begin
            baud_q <= baud_q + 12'd1;
          end
        end
        DATA: begin
          if (baud_done) begin
            baud_q <= '0;
            if (bit_q == 3'd7) begin
              state_q <= STOP;
              tx_q    <= 1'b1;
            end else begin
              bit_q   <= bit_q + 3'd1;
              shift_q <= {1'b0, shift_q[7:1]};
              tx_q    <= shift_q[1];
            end
          end else begin
            baud_q <= baud_q + 12'd1;
          end
        end
        STOP: begin
          if (baud_done) begin
            baud_q <= '0;
            // Chain straight into the next frame when bytes are waiting.
            if (pop) begin
              shift_q <= mem_q[rd_ptr_q];
              state_q <= START;
              tx_q    <= 1'b0;
            end else begin
              state_q <= IDLE;
              intr_q  <= 1'b1;
            end
          end else begin
            baud_q <= baud_q + 12'd1;
          end
        end
        default: begin
          state_q <= IDLE;
          tx_q    <= 1'b1;
        end
      endcase
    end
  end

  assign TX     = tx_q;
  assign INTR   = intr_q;
  assign STATUS = {1'b0, ovf_q, (state_q != IDLE), empty, full, count_q};

endmodule

// File: tb/tb_rat_uart_tx.sv
// Directed bench for rat_uart_tx at 4 clocks/bit: a line monitor decodes frames
// and compares them against a scoreboard of bytes queued by the stimulus.
module tb_rat_uart_tx;

  logic       CLK;
  logic       RESET_N;
  logic [7:0] PORT_ID;
  logic [7:0] OUT_PORT;
  logic       IO_STRB;
  logic       TX;
  logic [7:0] STATUS;
  logic       INTR;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int intr_cnt = 0;
  int frames_done = 0;
  logic [7:0] sb[$];
  int starts[$];

  rat_uart_tx #(.CLKS_PER_BIT(4), .TX_DATA_ID(8'h40), .TX_STAT_ID(8'h41)) dut (
    .CLK(CLK), .RESET_N(RESET_N), .PORT_ID(PORT_ID), .OUT_PORT(OUT_PORT),
    .IO_STRB(IO_STRB), .TX(TX), .STATUS(STATUS), .INTR(INTR)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  always @(posedge CLK) cyc <= cyc + 1;
  always @(posedge CLK) if (INTR === 1'b1) intr_cnt <= intr_cnt + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [7:0] id, input logic [7:0] d);
    @(negedge CLK);
    PORT_ID = id; OUT_PORT = d; IO_STRB = 1'b1;
    @(negedge CLK);
    IO_STRB = 1'b0; PORT_ID = 8'h00;
  endtask

  task automatic wait_frames(input int n, input int budget, input string tag);
    int k;
    k = 0;
    while (frames_done < n && k < budget) begin
      @(negedge CLK);
      k++;
    end
    chk(tag, frames_done, n);
  endtask

  task automatic check_gaps(input int n, input string tag);
    chk({tag, "_nframes"}, starts.size(), n);
    for (int k = 1; k < starts.size(); k++)
      chk({tag, "_gap"}, starts[k] - starts[k-1], 40);
  endtask

  // Line monitor: samples every cycle of a frame, decodes mid-bit, pops the scoreboard.
  initial begin : mon
    logic [39:0] smp;
    logic        abort, ok;
    logic [7:0]  b, e;
    int          st;
    forever begin
      @(negedge CLK);
      if (RESET_N === 1'b1 && TX === 1'b0) begin
        st = cyc; abort = 1'b0; smp = '0; smp[0] = TX;
        for (int c = 1; c < 40 && !abort; c++) begin
          @(negedge CLK);
          if (RESET_N !== 1'b1) abort = 1'b1;
          else smp[c] = TX;
        end
        if (!abort) begin
          starts.push_back(st);
          ok = (smp[3:0] == 4'h0) && (smp[39:36] == 4'hF);
          for (int i = 0; i < 8; i++) begin
            if (smp[4+4*i +: 4] != {4{smp[4+4*i]}}) ok = 1'b0;
            b[i] = smp[4+4*i+2];
          end
          chk("frame_expected", (sb.size() > 0), 1);
          if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("frame_shape", ok, 1);
            chk("frame_byte", b, e);
          end
          frames_done++;
        end
      end
    end
  end

  initial begin : stim
    int ib, fd;
    logic any_low;
    PORT_ID = 8'h00; OUT_PORT = 8'h00; IO_STRB = 1'b0;
    RESET_N = 1'b1;
    #1 RESET_N = 1'b0;
    repeat (2) @(negedge CLK);
    chk("rst_tx", TX, 1);
    chk("rst_status", STATUS, 8'h10);
    chk("rst_intr", INTR, 0);
    RESET_N = 1'b1;
    repeat (2) @(negedge CLK);

    // Single byte with exact latency and INTR timing
    ib = intr_cnt;
    sb.push_back(8'hA5);
    wr(8'h40, 8'hA5);
    chk("lat_status", STATUS, 8'h01);
    chk("lat_tx_idle", TX, 1);
    @(negedge CLK);
    chk("start_tx", TX, 0);
    chk("start_status", STATUS, 8'h30);
    repeat (39) @(negedge CLK);
    chk("stop_tx", TX, 1);
    chk("intr_pre", INTR, 0);
    @(negedge CLK);
    chk("intr_pulse", INTR, 1);
    chk("idle_status", STATUS, 8'h10);
    @(negedge CLK);
    chk("intr_once", INTR, 0);
    repeat (2) @(negedge CLK);
    chk("single_intr_cnt", intr_cnt - ib, 1);
    chk("single_frames", frames_done, 1);
    chk("single_sb_empty", sb.size(), 0);

    // Burst of five, then overflow and clear while full
    ib = intr_cnt; fd = frames_done; starts.delete();
    for (int i = 0; i < 5; i++) begin
      @(negedge CLK);
      PORT_ID = 8'h40; OUT_PORT = 8'(i + 1); IO_STRB = 1'b1;
      sb.push_back(8'(i + 1));
    end
    @(negedge CLK);
    IO_STRB = 1'b0; PORT_ID = 8'h00;
    chk("burst_full", STATUS, 8'h2C);
    wr(8'h40, 8'hFF);
    chk("ovf_set", STATUS, 8'h6C);
    wr(8'h41, 8'h00);
    chk("ovf_clr", STATUS, 8'h2C);
    wait_frames(fd + 5, 260, "burst_done");
    check_gaps(5, "burst");
    repeat (3) @(negedge CLK);
    chk("burst_intr", intr_cnt - ib, 1);
    chk("burst_status", STATUS, 8'h10);

    // Write lands on the edge where STOP ends with the FIFO full
    ib = intr_cnt; fd = frames_done; starts.delete();
    for (int i = 0; i < 5; i++) begin
      @(negedge CLK);
      PORT_ID = 8'h40; OUT_PORT = 8'(8'h11 + i); IO_STRB = 1'b1;
      sb.push_back(8'(8'h11 + i));
    end
    @(negedge CLK);
    IO_STRB = 1'b0; PORT_ID = 8'h00;
    repeat (36) @(negedge CLK);
    PORT_ID = 8'h40; OUT_PORT = 8'h16; IO_STRB = 1'b1;
    sb.push_back(8'h16);
    @(negedge CLK);
    IO_STRB = 1'b0; PORT_ID = 8'h00;
    chk("pushpop_status", STATUS, 8'h2C);
    wait_frames(fd + 6, 260, "pushpop_done");
    check_gaps(6, "pushpop");
    repeat (3) @(negedge CLK);
    chk("pushpop_intr", intr_cnt - ib, 1);
    chk("pushpop_sb_empty", sb.size(), 0);

    // Reset during DATA bit 3 (bit 3 of C3 is 0)
    ib = intr_cnt; fd = frames_done;
    sb.push_back(8'hC3);
    wr(8'h40, 8'hC3);
    repeat (18) @(negedge CLK);
    chk("pre_rst_status", STATUS, 8'h30);
    chk("pre_rst_tx", TX, 0);
    #2 RESET_N = 1'b0;
    #1;
    chk("async_rst_tx", TX, 1);
    chk("async_rst_status", STATUS, 8'h10);
    chk("async_rst_intr", INTR, 0);
    sb.delete();
    repeat (3) @(negedge CLK);
    RESET_N = 1'b1;
    repeat (50) @(negedge CLK);
    chk("rst_no_intr", intr_cnt - ib, 0);
    chk("rst_no_frame", frames_done, fd);
    wr(8'h42, 8'h55);
    chk("other_id_status", STATUS, 8'h10);
    any_low = 1'b0;
    repeat (45) begin
      @(negedge CLK);
      if (TX !== 1'b1) any_low = 1'b1;
    end
    chk("other_id_tx_idle", any_low, 0);
    chk("other_id_status_end", STATUS, 8'h10);
    chk("end_frames", frames_done, fd);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
